// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide engine with a start/busy/valid
// handshake. Multiply is radix-2 shift-add on magnitudes; divide is restoring
// division on magnitudes, one quotient bit per cycle. Signs are fixed up when
// the result is written.
//
// Optional build macro: MDU_FAST_MUL_EN
//   defined   -> all multiply ops use a combinational XLEN x XLEN multiplier and
//                complete on the cycle after accept, like the divide special cases.
//   undefined -> multiply ops take the iterative XLEN-cycle path.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's-complement negate when requested (XLEN wide).
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    cond_neg = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement negate when requested (2*XLEN wide).
  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    cond_neg2 = neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier then product low / dividend then quotient
  logic [XLEN-1:0] mcand_q, mcand_d; // |multiplicand| or |divisor|
  logic            neg_q, neg_d;     // negate the selected result at the end
  logic            sc_q, sc_d;       // shortcut: lo_q already holds the final result
  logic [2:0]      op_q, op_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] div_sel, final_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Operand decode, one iteration step of each engine, and final sign fix-up.
  always_comb begin
    // MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH also rs2; DIV/REM both signed.
    if (funct3_i[2]) begin
      a_signed = ~funct3_i[0];
      b_signed = ~funct3_i[0];
    end else begin
      a_signed = (funct3_i[1:0] != 2'b11);
      b_signed = ~funct3_i[1];
    end
    a_neg = a_signed & op_a_i[XLEN-1];
    b_neg = b_signed & op_b_i[XLEN-1];
    mag_a = cond_neg(op_a_i, a_neg);
    mag_b = cond_neg(op_b_i, b_neg);
`ifdef MDU_FAST_MUL_EN
    fast_prod = cond_neg2({{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, a_neg ^ b_neg);
`endif
    // Shift-add: add multiplicand into the high half when the multiplier LSB is set.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    // Restoring divide: the top bit of div_diff is the borrow (trial failed).
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    prod_fix  = cond_neg2({hi_q, lo_q}, neg_q);
    div_sel   = op_q[1] ? hi_q : lo_q;
    if (op_q[2]) begin
      final_res = cond_neg(div_sel, neg_q);
    end else if (op_q[1:0] == 2'b00) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic: accept, iterate, write result on entering DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    sc_d     = sc_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          op_d    = funct3_i;
          cnt_d   = '0;
          hi_d    = '0;
          neg_d   = 1'b0;
          sc_d    = 1'b0;
          if (funct3_i[2]) begin
            if (op_b_i == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              sc_d = 1'b1;
              lo_d = funct3_i[1] ? op_a_i : '1;
            end else if (!funct3_i[0] && (op_a_i == INT_MIN) && (op_b_i == '1)) begin
              // Signed overflow: quotient is the dividend, remainder zero.
              sc_d = 1'b1;
              lo_d = funct3_i[1] ? '0 : op_a_i;
            end else begin
              lo_d    = mag_a;
              mcand_d = mag_b;
              neg_d   = funct3_i[1] ? a_neg : (a_neg ^ b_neg);
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            sc_d = 1'b1;
            lo_d = (funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
            lo_d    = mag_b;
            mcand_d = mag_a;
            neg_d   = a_neg ^ b_neg;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (sc_q || (cnt_q == LAST_CNT)) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = sc_q ? lo_q : final_res;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (op_q[2]) begin
            if (div_diff[XLEN]) begin
              hi_d = div_shift[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end else begin
              hi_d = div_diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      sc_q     <= 1'b0;
      op_q     <= 3'b000;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      sc_q     <= sc_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (XLEN=32).
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev_res = 32'h0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, and check timing and result.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = ~f;
    op_a   = 32'hDEADBEEF;
    op_b   = 32'h0;
    chk({tag, "_busy_acc"}, {31'b0, busy}, 32'd1);
    chk({tag, "_held"}, result, prev_res);
    n = 0;
    while (!valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, result, exp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'b0, valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    prev_res = exp;
  endtask

  initial begin
    int pulses;
    logic [31:0] got;
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = 32'h0;
    op_b   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply
    do_op("mul_neg",  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    do_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    do_op("mulhu_m1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    do_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    do_op("mul_pos",  3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT);
    do_op("mulhu_sm", 3'b011, 32'h12345678, 32'h00000010, 32'h00000001, MUL_LAT);

    // Divide
    do_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    do_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    do_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
    do_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
    do_op("div_nb",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
    do_op("rem_nb",   3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT);
    do_op("divu_big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0,        DIV_LAT);
    do_op("remu_big", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT);

    // Special cases
    do_op("div_z",    3'b100, 32'd5,        32'h0,        32'hFFFFFFFF, SPC_LAT);
    do_op("remu_z",   3'b111, 32'd5,        32'h0,        32'd5,        SPC_LAT);
    do_op("divu_z",   3'b101, 32'd5,        32'h0,        32'hFFFFFFFF, SPC_LAT);
    do_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
    do_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        SPC_LAT);

    // start held with new operands during CALC must be ignored
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    @(posedge clk);
    #1;
    funct3 = 3'b000;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    got    = 32'h0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        got = result;
      end
    end
    chk("hold_pulses", pulses, 32'd1);
    chk("hold_res", got, 32'd14);
    chk("hold_idle", {31'b0, busy}, 32'd0);

    // Reset in the middle of a DIVU
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'hFFFFFFFF;
    op_b   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_valid", {31'b0, valid}, 32'd0);
    chk("mrst_result", result, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    chk("mrst_no_late", pulses, 32'd0);
    prev_res = 32'h0;
    do_op("post_rst", 3'b101, 32'hFFFFFFFF, 32'd3, 32'h55555555, DIV_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
